// File: rtl/dmem_block_mover_if.sv
// Command and memory-port bundle for dmem_block_mover.
// master = the mover engine; slave = the CPU/memory side that drives commands and read data.
interface dmem_block_mover_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              Start;
   logic              Mode;
   logic [ADDR_W-1:0] SrcAddr;
   logic [ADDR_W-1:0] DstAddr;
   logic [ADDR_W-1:0] Length;
   logic [DATA_W-1:0] FillValue;
   logic [DATA_W-1:0] MemDataIn;
   logic [ADDR_W-1:0] MemAddress;
   logic              MemWriteEn;
   logic [DATA_W-1:0] MemDataOut;
   logic              Busy;
   logic              Done;

   modport master (
      input  Start, Mode, SrcAddr, DstAddr, Length, FillValue, MemDataIn,
      output MemAddress, MemWriteEn, MemDataOut, Busy, Done
   );

   modport slave (
      output Start, Mode, SrcAddr, DstAddr, Length, FillValue, MemDataIn,
      input  MemAddress, MemWriteEn, MemDataOut, Busy, Done
   );
endinterface

// File: rtl/dmem_block_mover.sv
// Block copy/fill engine driving the data-memory port. Copy: 2*Length+1 cycles to Done; fill: Length+1.
// No backpressure: memory is single-cycle; Start is only sampled in IDLE and ignored otherwise.
module dmem_block_mover #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input logic                  Clk,
   input logic                  Reset,
   dmem_block_mover_if.master   bus
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] i_q,     i_d;
   logic [DATA_W-1:0] buf_q,   buf_d;
   logic              mode_q,  mode_d;
   logic [ADDR_W-1:0] src_q,   src_d;
   logic [ADDR_W-1:0] dst_q,   dst_d;
   logic [ADDR_W-1:0] len_q,   len_d;
   logic [DATA_W-1:0] fill_q,  fill_d;
   logic              last_c;

   assign last_c = (i_q == (len_q - ONE));

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      buf_d   = buf_q;
      mode_d  = mode_q;
      src_d   = src_q;
      dst_d   = dst_q;
      len_d   = len_q;
      fill_d  = fill_q;
      case (state_q)
         S_IDLE: begin
            if (bus.Start) begin
               mode_d = bus.Mode;
               src_d  = bus.SrcAddr;
               dst_d  = bus.DstAddr;
               len_d  = bus.Length;
               fill_d = bus.FillValue;
               i_d    = '0;
               if (bus.Length == '0) state_d = S_DONE;
               else if (bus.Mode)    state_d = S_WRITE;
               else                  state_d = S_READ;
            end
         end
         S_READ: begin
            buf_d   = bus.MemDataIn;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            // Ascending order means an overlapping dst>src copy re-reads bytes it just wrote.
            if (last_c) begin
               state_d = S_DONE;
            end else begin
               i_d     = i_q + ONE;
               state_d = mode_q ? S_WRITE : S_READ;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q <= S_IDLE;
         i_q     <= '0;
         buf_q   <= '0;
         mode_q  <= 1'b0;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         fill_q  <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         buf_q   <= buf_d;
         mode_q  <= mode_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         len_q   <= len_d;
         fill_q  <= fill_d;
      end
   end

   // Outputs depend on registers only, so the external port mux sees no input-to-output paths.
   assign bus.MemAddress = (state_q == S_READ)  ? (src_q + i_q) :
                           (state_q == S_WRITE) ? (dst_q + i_q) : '0;
   assign bus.MemWriteEn = (state_q == S_WRITE);
   assign bus.MemDataOut = (state_q == S_WRITE) ? (mode_q ? fill_q : buf_q) : '0;
   assign bus.Busy       = (state_q == S_READ) || (state_q == S_WRITE);
   assign bus.Done       = (state_q == S_DONE);

endmodule

// File: tb/tb_dmem_block_mover.sv
// Directed bench for dmem_block_mover with a 256x8 behavioural memory on the port.
module tb_dmem_block_mover;

   logic Clk = 1'b0;
   logic Reset;

   always #5 Clk = ~Clk;

   dmem_block_mover_if #(.ADDR_W(8), .DATA_W(8)) bus ();

   dmem_block_mover #(.ADDR_W(8), .DATA_W(8)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   logic [7:0] mem [256];
   logic       tb_we;
   logic [7:0] tb_addr;
   logic [7:0] tb_dat;

   assign bus.MemDataIn = mem[bus.MemAddress];

   always @(posedge Clk) begin
      if (tb_we)          mem[tb_addr]        <= tb_dat;
      if (bus.MemWriteEn) mem[bus.MemAddress] <= bus.MemDataOut;
   end

   int compared   = 0;
   int mismatched = 0;

   logic [7:0] r_busy, r_we, r_done, r_a1, r_a2, r_d2, done_seen;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=0x%0h required=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [7:0] a, input logic [7:0] d);
      tb_we   = 1'b1;
      tb_addr = a;
      tb_dat  = d;
      @(negedge Clk);
      tb_we   = 1'b0;
   endtask

   // Issues one command from IDLE, scrambles the command inputs after the accepting edge,
   // optionally pulses Start at cycle pulse_at, and records cycle-level observations.
   task automatic run_cmd(input logic mode, input logic [7:0] src, input logic [7:0] dst,
                          input logic [7:0] len, input logic [7:0] fill, input int pulse_at);
      bus.Start     = 1'b1;
      bus.Mode      = mode;
      bus.SrcAddr   = src;
      bus.DstAddr   = dst;
      bus.Length    = len;
      bus.FillValue = fill;
      @(negedge Clk);
      bus.Start     = 1'b0;
      bus.Mode      = ~mode;
      bus.SrcAddr   = 8'h33;
      bus.DstAddr   = 8'h44;
      bus.Length    = 8'hFF;
      bus.FillValue = 8'hCC;
      r_busy = 8'd0; r_we = 8'd0; r_done = 8'd0;
      r_a1 = 8'd0; r_a2 = 8'd0; r_d2 = 8'd0;
      for (int k = 1; k <= 600; k++) begin
         if (bus.Busy)       r_busy++;
         if (bus.MemWriteEn) r_we++;
         if (k == 1) r_a1 = bus.MemAddress;
         if (k == 2) begin
            r_a2 = bus.MemAddress;
            r_d2 = bus.MemDataOut;
         end
         if (bus.Done) begin
            r_done = 8'(k);
            break;
         end
         bus.Start = (k == pulse_at);
         @(negedge Clk);
      end
      bus.Start = 1'b0;
      @(negedge Clk);
   endtask

   initial begin
      Reset = 1'b0;
      tb_we = 1'b0; tb_addr = 8'h00; tb_dat = 8'h00;
      bus.Start = 1'b1; bus.Mode = 1'b0; bus.SrcAddr = 8'h10; bus.DstAddr = 8'h80;
      bus.Length = 8'd4; bus.FillValue = 8'h00;
      repeat (3) @(negedge Clk);

      // Reset state, with Start held high to show reset dominates.
      check("rst_busy", {7'd0, bus.Busy},       8'd0);
      check("rst_done", {7'd0, bus.Done},       8'd0);
      check("rst_we",   {7'd0, bus.MemWriteEn}, 8'd0);
      check("rst_addr", bus.MemAddress,         8'h00);
      check("rst_dout", bus.MemDataOut,         8'h00);
      bus.Start = 1'b0;
      Reset = 1'b1;
      @(negedge Clk);
      check("idle_busy", {7'd0, bus.Busy}, 8'd0);

      poke(8'h10, 8'h11); poke(8'h11, 8'h22); poke(8'h12, 8'h33); poke(8'h13, 8'h44);
      poke(8'hF3, 8'h5A);
      poke(8'hFE, 8'h01); poke(8'hFF, 8'h02); poke(8'h00, 8'h03); poke(8'h01, 8'h04);
      poke(8'h20, 8'h07); poke(8'h21, 8'hEE); poke(8'h22, 8'hEE); poke(8'h23, 8'hEE);
      poke(8'h24, 8'h99); poke(8'h40, 8'h00); poke(8'h44, 8'h00);
      for (int a = 8'h60; a < 8'h6A; a++) poke(8'(a), 8'h00);

      // Plain copy.
      run_cmd(1'b0, 8'h10, 8'h80, 8'd4, 8'h00, 0);
      check("copy_busy_cycles", r_busy, 8'd8);
      check("copy_done_cycle",  r_done, 8'd9);
      check("copy_we_cycles",   r_we,   8'd4);
      check("copy_read_addr",   r_a1,   8'h10);
      check("copy_write_addr",  r_a2,   8'h80);
      check("copy_write_data",  r_d2,   8'h11);
      check("copy_m80", mem[8'h80], 8'h11);
      check("copy_m81", mem[8'h81], 8'h22);
      check("copy_m82", mem[8'h82], 8'h33);
      check("copy_m83", mem[8'h83], 8'h44);
      check("copy_m44_untouched", mem[8'h44], 8'h00);

      // Fill.
      run_cmd(1'b1, 8'h00, 8'hF0, 8'd3, 8'hA5, 0);
      check("fill_done_cycle",  r_done, 8'd4);
      check("fill_busy_cycles", r_busy, 8'd3);
      check("fill_addr1",       r_a1,   8'hF0);
      check("fill_addr2",       r_a2,   8'hF1);
      check("fill_data2",       r_d2,   8'hA5);
      check("fill_mF0", mem[8'hF0], 8'hA5);
      check("fill_mF1", mem[8'hF1], 8'hA5);
      check("fill_mF2", mem[8'hF2], 8'hA5);
      check("fill_mF3_kept", mem[8'hF3], 8'h5A);

      // Source address wraps past 0xFF.
      run_cmd(1'b0, 8'hFE, 8'h02, 8'd4, 8'h00, 0);
      check("wrap_done_cycle", r_done, 8'd9);
      check("wrap_m02", mem[8'h02], 8'h01);
      check("wrap_m03", mem[8'h03], 8'h02);
      check("wrap_m04", mem[8'h04], 8'h03);
      check("wrap_m05", mem[8'h05], 8'h04);

      // Zero length.
      run_cmd(1'b1, 8'h10, 8'h30, 8'd0, 8'hBB, 0);
      check("len0_done_cycle",  r_done, 8'd1);
      check("len0_busy_cycles", r_busy, 8'd0);
      check("len0_we_cycles",   r_we,   8'd0);

      // Overlapping copy with a Start pulse during the transfer (fill 0xCC to 0x44 if obeyed).
      run_cmd(1'b0, 8'h20, 8'h21, 8'd3, 8'h00, 3);
      check("ovl_done_cycle", r_done, 8'd7);
      check("ovl_m21", mem[8'h21], 8'h07);
      check("ovl_m22", mem[8'h22], 8'h07);
      check("ovl_m23", mem[8'h23], 8'h07);
      check("ovl_m24_kept", mem[8'h24], 8'h99);
      check("ovl_after_busy", {7'd0, bus.Busy}, 8'd0);
      check("ovl_m44_kept", mem[8'h44], 8'h00);

      // Reset during the fourth READ of a 10-byte copy.
      bus.Start = 1'b1; bus.Mode = 1'b0; bus.SrcAddr = 8'h10; bus.DstAddr = 8'h60;
      bus.Length = 8'd10; bus.FillValue = 8'h00;
      @(negedge Clk);
      bus.Start = 1'b0;
      repeat (6) @(negedge Clk);
      check("abort_pre_busy", {7'd0, bus.Busy}, 8'd1);
      check("abort_pre_addr", bus.MemAddress,   8'h13);
      Reset = 1'b0;
      @(negedge Clk);
      check("abort_busy", {7'd0, bus.Busy},       8'd0);
      check("abort_done", {7'd0, bus.Done},       8'd0);
      check("abort_we",   {7'd0, bus.MemWriteEn}, 8'd0);
      check("abort_addr", bus.MemAddress,         8'h00);
      check("abort_dout", bus.MemDataOut,         8'h00);
      Reset = 1'b1;
      done_seen = 8'd0;
      for (int k = 0; k < 20; k++) begin
         @(negedge Clk);
         if (bus.Done || bus.Busy) done_seen++;
      end
      check("abort_no_activity", done_seen, 8'd0);
      check("abort_m60", mem[8'h60], 8'h11);
      check("abort_m61", mem[8'h61], 8'h22);
      check("abort_m62", mem[8'h62], 8'h33);
      check("abort_m63_kept", mem[8'h63], 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
